spec_rollback_ctrl: RTL

//  Sequencer in front of spec_vector. Admits speculative branches from decode and stalls them when the spec depth is full or a rollback is active.
//  On a mispredict it captures the fail context, then runs a fixed sequence: flush, serial tag-map restore, fetch redirect.
//  It holds issue and cond write-back off until the redirect completes.

---
 rtl/spec_rollback_ctrl_pkg.sv | 26 ++
 rtl/spec_rollback_ctrl_if.sv | 60 ++++++
 rtl/spec_rollback_ctrl_sat_counter.sv | 23 ++
 rtl/spec_rollback_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/spec_rollback_ctrl_pkg.sv
// Shared types and sizing for the speculative-branch rollback sequencer.
// Also holds the helper that picks one register id out of a packed tag map.
package spec_pkg;
   localparam int NUM_TAG        = 4;
   localparam int NUM_REG        = 8;
   localparam int SPEC_DEPTH     = 4;
   localparam int PC_BIT         = 4;
   localparam int INST_ID_BIT    = 8;
   localparam int REG_ID_BIT     = $clog2(NUM_REG);
   localparam int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1;
   localparam int TAG_IDX_BIT    = $clog2(NUM_TAG);
   localparam int TAG_MAP_BIT    = NUM_TAG * REG_ID_BIT;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_RESTORE  = 2'd2,
      ST_REDIRECT = 2'd3
   } state_t;

   // Entry i of a tag map lives in bits [i*REG_ID_BIT +: REG_ID_BIT].
   function automatic logic [REG_ID_BIT-1:0] tag_slice(input logic [TAG_MAP_BIT-1:0] map,
                                                       input logic [TAG_IDX_BIT-1:0] idx);
      return map[idx*REG_ID_BIT +: REG_ID_BIT];
   endfunction
endpackage

// File: rtl/spec_rollback_ctrl_if.sv
// Bundle between the rollback sequencer and decode / spec_vector / issue / fetch.
// Handshake: decode holds dec_br_req with stable fields until dec_br_ack is seen high in a cycle.
interface spec_rollback_ctrl_if #(
   parameter int CNT_BIT = 16
);
   import spec_pkg::*;

   logic                      dec_br_req;
   logic [REG_ID_BIT-1:0]     dec_br_cond_reg;
   logic                      dec_br_pred_val;
   logic [PC_BIT-1:0]         dec_br_rb_pc;
   logic [INST_ID_BIT-1:0]    dec_br_rb_id;
   logic [TAG_MAP_BIT-1:0]    cur_tag_map;
   logic                      dec_br_ack;
   logic                      sv_br_vld;
   logic [REG_ID_BIT-1:0]     sv_br_cond_reg;
   logic                      sv_br_pred_val;
   logic [PC_BIT-1:0]         sv_br_rb_pc;
   logic [INST_ID_BIT-1:0]    sv_br_rb_id;
   logic [TAG_MAP_BIT-1:0]    sv_br_rb_tag_map;
   logic [SPEC_LEVEL_BIT-1:0] sv_cur_spec_level;
   logic                      sv_pred_vld;
   logic                      sv_pred_succ;
   logic [SPEC_LEVEL_BIT-1:0] sv_fail_level;
   logic [TAG_MAP_BIT-1:0]    sv_fail_tag_map;
   logic [PC_BIT-1:0]         sv_fail_pc;
   logic [INST_ID_BIT-1:0]    sv_fail_id;
   logic                      cond_wb_hold;
   logic                      issue_stall;
   logic                      flush_vld;
   logic [SPEC_LEVEL_BIT-1:0] flush_level;
   logic                      tag_wr_vld;
   logic [TAG_IDX_BIT-1:0]    tag_wr_idx;
   logic [REG_ID_BIT-1:0]     tag_wr_reg;
   logic                      redirect_vld;
   logic [PC_BIT-1:0]         redirect_pc;
   logic [INST_ID_BIT-1:0]    redirect_id;
   logic [CNT_BIT-1:0]        mispred_cnt;
   state_t                    dbg_state;

   modport master (
      input  dec_br_req, dec_br_cond_reg, dec_br_pred_val, dec_br_rb_pc, dec_br_rb_id,
             cur_tag_map, sv_cur_spec_level, sv_pred_vld, sv_pred_succ, sv_fail_level,
             sv_fail_tag_map, sv_fail_pc, sv_fail_id,
      output dec_br_ack, sv_br_vld, sv_br_cond_reg, sv_br_pred_val, sv_br_rb_pc, sv_br_rb_id,
             sv_br_rb_tag_map, cond_wb_hold, issue_stall, flush_vld, flush_level, tag_wr_vld,
             tag_wr_idx, tag_wr_reg, redirect_vld, redirect_pc, redirect_id, mispred_cnt,
             dbg_state
   );

   modport slave (
      output dec_br_req, dec_br_cond_reg, dec_br_pred_val, dec_br_rb_pc, dec_br_rb_id,
             cur_tag_map, sv_cur_spec_level, sv_pred_vld, sv_pred_succ, sv_fail_level,
             sv_fail_tag_map, sv_fail_pc, sv_fail_id,
      input  dec_br_ack, sv_br_vld, sv_br_cond_reg, sv_br_pred_val, sv_br_rb_pc, sv_br_rb_id,
             sv_br_rb_tag_map, cond_wb_hold, issue_stall, flush_vld, flush_level, tag_wr_vld,
             tag_wr_idx, tag_wr_reg, redirect_vld, redirect_pc, redirect_id, mispred_cnt,
             dbg_state
   );
endinterface

// File: rtl/spec_rollback_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !(&cnt_q)) cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/spec_rollback_ctrl.sv
// Admits speculative branches into spec_vector and, on a mispredict, sequences
// flush -> serial tag-map restore -> fetch redirect while holding issue and cond write-back.
module spec_rollback_ctrl #(
   parameter int CNT_BIT = 16
) (
   input logic                 clk,
   input logic                 rst,
   spec_rollback_ctrl_if.master bus_io
);
   import spec_pkg::*;

   state_t                    state_q, state_d;
   logic [TAG_IDX_BIT-1:0]    idx_q, idx_d;
   logic [SPEC_LEVEL_BIT-1:0] fail_level_q;
   logic [TAG_MAP_BIT-1:0]    fail_map_q;
   logic [PC_BIT-1:0]         fail_pc_q;
   logic [INST_ID_BIT-1:0]    fail_id_q;
   logic                      mispred;
   logic                      has_room;
   logic                      br_ack;

   assign mispred  = (state_q == ST_IDLE) & bus_io.sv_pred_vld & ~bus_io.sv_pred_succ;
   // A same-cycle success frees a level, so a full spec depth still admits the branch.
   assign has_room = (bus_io.sv_cur_spec_level != SPEC_LEVEL_BIT'(SPEC_DEPTH)) |
                     (bus_io.sv_pred_vld & bus_io.sv_pred_succ);
   assign br_ack   = (state_q == ST_IDLE) & bus_io.dec_br_req & has_room & ~mispred;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         fail_level_q <= '0;
         fail_map_q   <= '0;
         fail_pc_q    <= '0;
         fail_id_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (mispred) begin
            fail_level_q <= bus_io.sv_fail_level;
            fail_map_q   <= bus_io.sv_fail_tag_map;
            fail_pc_q    <= bus_io.sv_fail_pc;
            fail_id_q    <= bus_io.sv_fail_id;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE:     if (mispred) state_d = ST_FLUSH;
         ST_FLUSH: begin
            state_d = ST_RESTORE;
            idx_d   = '0;
         end
         ST_RESTORE: begin
            idx_d = idx_q + TAG_IDX_BIT'(1);
            if (idx_q == TAG_IDX_BIT'(NUM_TAG - 1)) begin
               state_d = ST_REDIRECT;
               idx_d   = '0;
            end
         end
         ST_REDIRECT: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus_io.dec_br_ack       = 1'b0;
      bus_io.sv_br_vld        = 1'b0;
      bus_io.sv_br_cond_reg   = bus_io.dec_br_cond_reg;
      bus_io.sv_br_pred_val   = bus_io.dec_br_pred_val;
      bus_io.sv_br_rb_pc      = bus_io.dec_br_rb_pc;
      bus_io.sv_br_rb_id      = bus_io.dec_br_rb_id;
      bus_io.sv_br_rb_tag_map = bus_io.cur_tag_map;
      bus_io.cond_wb_hold     = 1'b0;
      bus_io.issue_stall      = 1'b0;
      bus_io.flush_vld        = 1'b0;
      bus_io.flush_level      = '0;
      bus_io.tag_wr_vld       = 1'b0;
      bus_io.tag_wr_idx       = '0;
      bus_io.tag_wr_reg       = '0;
      bus_io.redirect_vld     = 1'b0;
      bus_io.redirect_pc      = '0;
      bus_io.redirect_id      = '0;
      if (state_q == ST_IDLE) begin
         bus_io.dec_br_ack = br_ack;
         bus_io.sv_br_vld  = br_ack;
      end else begin
         bus_io.cond_wb_hold = 1'b1;
         bus_io.issue_stall  = 1'b1;
      end
      case (state_q)
         ST_FLUSH: begin
            bus_io.flush_vld   = 1'b1;
            bus_io.flush_level = fail_level_q;
         end
         ST_RESTORE: begin
            bus_io.tag_wr_vld = 1'b1;
            bus_io.tag_wr_idx = idx_q;
            bus_io.tag_wr_reg = tag_slice(fail_map_q, idx_q);
         end
         ST_REDIRECT: begin
            bus_io.redirect_vld = 1'b1;
            bus_io.redirect_pc  = fail_pc_q;
            bus_io.redirect_id  = fail_id_q;
         end
         default: ;
      endcase
   end

   assign bus_io.dbg_state = state_q;

   sat_counter #(.WIDTH(CNT_BIT)) u_mispred_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (mispred),
      .cnt_o (bus_io.mispred_cnt)
   );
endmodule
